// File: rtl/flexbex_efpga_bridge_if.sv
// Signal bundle between the flexbex core, the eFPGA bridge and the eFPGA fabric.
// The bridge connects through the slave modport; the core/fabric side uses master.
interface flexbex_efpga_bridge_if;
  logic        efpga_en_i;
  logic [1:0]  efpga_operator_i;
  logic [31:0] efpga_operand_a_i;
  logic [31:0] efpga_operand_b_i;
  logic [3:0]  efpga_delay_i;
  logic        efpga_write_strobe_i;
  logic        efpga_done_o;
  logic [31:0] efpga_result_a_o;
  logic [31:0] efpga_result_b_o;
  logic [31:0] efpga_result_c_o;
  logic [31:0] fab_operand_a_o;
  logic [31:0] fab_operand_b_o;
  logic [1:0]  fab_operator_o;
  logic        fab_start_o;
  logic        fab_wr_o;
  logic [31:0] fab_result_a_i;
  logic [31:0] fab_result_b_i;
  logic [31:0] fab_result_c_i;
  logic        fab_done_i;
  logic        busy_o;
  logic        err_o;

  modport slave (
    input  efpga_en_i, efpga_operator_i, efpga_operand_a_i, efpga_operand_b_i,
           efpga_delay_i, efpga_write_strobe_i,
           fab_result_a_i, fab_result_b_i, fab_result_c_i, fab_done_i,
    output efpga_done_o, efpga_result_a_o, efpga_result_b_o, efpga_result_c_o,
           fab_operand_a_o, fab_operand_b_o, fab_operator_o, fab_start_o, fab_wr_o,
           busy_o, err_o
  );

  modport master (
    output efpga_en_i, efpga_operator_i, efpga_operand_a_i, efpga_operand_b_i,
           efpga_delay_i, efpga_write_strobe_i,
           fab_result_a_i, fab_result_b_i, fab_result_c_i, fab_done_i,
    input  efpga_done_o, efpga_result_a_o, efpga_result_b_o, efpga_result_c_o,
           fab_operand_a_o, fab_operand_b_o, fab_operator_o, fab_start_o, fab_wr_o,
           busy_o, err_o
  );
endinterface

// File: rtl/flexbex_efpga_bridge.sv
// flexbex eFPGA bridge: launches the fabric, enforces the minimum delay, captures results.
// Defining FLEXBEX_EFPGA_TIMEOUT_EN bounds the handshake wait by TIMEOUT_CYCLES.
module flexbex_efpga_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  flexbex_efpga_bridge_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_HOLD
  } state_e;

  state_e      r_state;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [1:0]  r_operator;
  logic [3:0]  r_cnt;
  logic        r_doneSeen;
  logic        r_start;
  logic        r_wr;
  logic        r_done;
  logic        r_busy;
  logic        r_err;
  logic [31:0] r_resA;
  logic [31:0] r_resB;
  logic [31:0] r_resC;

  logic        w_handshake;
  logic        w_doneNow;
  logic        w_waitOver;
  logic        w_timeout;

  assign w_handshake = r_operator[0];
  // A fabric done sampled in the exit cycle itself must count, so bypass the sticky flag.
  assign w_doneNow   = r_doneSeen | io_bus.fab_done_i;
  assign w_waitOver  = (r_cnt == 4'd0) && (!w_handshake || w_doneNow);

`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_waitCnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || r_state != S_WAIT || !w_handshake) begin
      r_waitCnt <= 8'd0;
    end else begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  assign w_timeout = w_handshake && !w_waitOver && (r_waitCnt == TimeoutLast);
`else
  // TIMEOUT_CYCLES has no effect without the timeout feature.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_opA      <= 32'd0;
      r_opB      <= 32'd0;
      r_operator <= 2'd0;
      r_cnt      <= 4'd0;
      r_doneSeen <= 1'b0;
      r_start    <= 1'b0;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_resA     <= 32'd0;
      r_resB     <= 32'd0;
      r_resC     <= 32'd0;
    end else begin
      r_start <= 1'b0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.efpga_en_i) begin
            r_opA      <= io_bus.efpga_operand_a_i;
            r_opB      <= io_bus.efpga_operand_b_i;
            r_operator <= io_bus.efpga_operator_i;
            r_cnt      <= io_bus.efpga_delay_i;
            r_doneSeen <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_LAUNCH;
          end else if (io_bus.efpga_write_strobe_i) begin
            r_opA <= io_bus.efpga_operand_a_i;
            r_opB <= io_bus.efpga_operand_b_i;
            r_wr  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (io_bus.fab_done_i) begin
            r_doneSeen <= 1'b1;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (io_bus.fab_done_i) begin
            r_doneSeen <= 1'b1;
          end
          if (w_waitOver || w_timeout) begin
            r_err   <= w_timeout;
            r_state <= S_CAPTURE;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (r_err) begin
            r_resA <= 32'hFFFF_FFFF;
            r_resB <= 32'hFFFF_FFFF;
            r_resC <= 32'hFFFF_FFFF;
          end else begin
            r_resA <= io_bus.fab_result_a_i;
            r_resB <= io_bus.fab_result_b_i;
            r_resC <= io_bus.fab_result_c_i;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Core still requesting: park in HOLD so the same request cannot relaunch.
          r_busy  <= io_bus.efpga_en_i;
          r_state <= io_bus.efpga_en_i ? S_HOLD : S_IDLE;
        end
        S_HOLD: begin
          if (!io_bus.efpga_en_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.efpga_done_o     = r_done;
  assign io_bus.efpga_result_a_o = r_resA;
  assign io_bus.efpga_result_b_o = r_resB;
  assign io_bus.efpga_result_c_o = r_resC;
  assign io_bus.fab_operand_a_o  = r_opA;
  assign io_bus.fab_operand_b_o  = r_opB;
  assign io_bus.fab_operator_o   = r_operator;
  assign io_bus.fab_start_o      = r_start;
  assign io_bus.fab_wr_o         = r_wr;
  assign io_bus.busy_o           = r_busy;
  assign io_bus.err_o            = r_err;

endmodule

// File: tb/tb_flexbex_efpga_bridge.sv
// Self-checking bench for flexbex_efpga_bridge: cycle-arithmetic reference model plus directed tests.
// The timeout scenario is exercised when FLEXBEX_EFPGA_TIMEOUT_EN is defined.
module tb_flexbex_efpga_bridge;

  localparam int TbTimeout = 16;
`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
  localparam int LateK     = 12;
`else
  localparam bit TimeoutOn = 1'b0;
  localparam int LateK     = 20;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   doneCount = 0;
  int   startCount = 0;
  int   lastDoneEdge = 0;
  int   lastStartEdge = 0;

  flexbex_efpga_bridge_if bus ();

  flexbex_efpga_bridge #(.TIMEOUT_CYCLES(TbTimeout)) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: operation timing expressed as edge offsets from the launch edge.
  bit          mActive = 1'b0;
  bit          mHold = 1'b0;
  bit          mHs = 1'b0;
  bit          mTimedOut = 1'b0;
  int          mL = 0;
  int          mD = 0;
  int          mFab = -1;
  int          mExit = -1;
  logic [31:0] expOpA = 32'd0;
  logic [31:0] expOpB = 32'd0;
  logic [1:0]  expOper = 2'd0;
  logic [31:0] expResA = 32'd0;
  logic [31:0] expResB = 32'd0;
  logic [31:0] expResC = 32'd0;
  logic        expStart = 1'b0;
  logic        expWr = 1'b0;
  logic        expDone = 1'b0;
  logic        expBusy = 1'b0;
  logic        expErr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] d, input logic strobe);
    bus.efpga_en_i           = en;
    bus.efpga_operator_i     = op;
    bus.efpga_operand_a_i    = a;
    bus.efpga_operand_b_i    = b;
    bus.efpga_delay_i        = d;
    bus.efpga_write_strobe_i = strobe;
  endtask

  task automatic waitForDone(input int budget, input string name);
    int n = 0;
    while (bus.efpga_done_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.efpga_done_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: done_o=%b after %0d cycles, required 1", name, bus.efpga_done_o, budget);
    end
  endtask

  // Edge n ends spec cycle (n - mL); outputs computed here are those of the following cycle.
  always @(posedge clk) begin : modelProc
    int rel;
    cyc++;
    expStart = 1'b0;
    expWr    = 1'b0;
    expDone  = 1'b0;
    if (!rstN) begin
      mActive = 1'b0; mHold = 1'b0; mTimedOut = 1'b0;
      expOpA = 32'd0; expOpB = 32'd0; expOper = 2'd0;
      expResA = 32'd0; expResB = 32'd0; expResC = 32'd0;
      expBusy = 1'b0; expErr = 1'b0;
    end else if (mActive) begin
      rel = cyc - mL;
      if (mHs && bus.fab_done_i && mFab < 0 && mExit < 0) mFab = rel;
      if (mExit < 0) begin
        if (rel >= mD + 2 && (!mHs || mFab >= 0)) begin
          mExit = rel;
        end else if (TimeoutOn && mHs && rel == TbTimeout + 1) begin
          mExit = rel;
          mTimedOut = 1'b1;
          expErr = 1'b1;
        end
      end else if (rel == mExit + 1) begin
        expResA = mTimedOut ? 32'hFFFF_FFFF : bus.fab_result_a_i;
        expResB = mTimedOut ? 32'hFFFF_FFFF : bus.fab_result_b_i;
        expResC = mTimedOut ? 32'hFFFF_FFFF : bus.fab_result_c_i;
        expDone = 1'b1;
      end else if (rel == mExit + 2) begin
        mActive = 1'b0;
        mHold   = bus.efpga_en_i;
      end
      expBusy = mActive || mHold;
    end else if (mHold) begin
      if (!bus.efpga_en_i) mHold = 1'b0;
      expBusy = mHold;
    end else begin
      if (bus.efpga_en_i) begin
        mActive = 1'b1; mL = cyc; mD = int'(bus.efpga_delay_i); mHs = bus.efpga_operator_i[0];
        mFab = -1; mExit = -1; mTimedOut = 1'b0;
        expErr = 1'b0; expOpA = bus.efpga_operand_a_i; expOpB = bus.efpga_operand_b_i;
        expOper = bus.efpga_operator_i; expStart = 1'b1; expBusy = 1'b1;
      end else if (bus.efpga_write_strobe_i) begin
        expOpA = bus.efpga_operand_a_i;
        expOpB = bus.efpga_operand_b_i;
        expWr  = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cyc > 0) begin
      checkOutput("done_o", bus.efpga_done_o, expDone);
      checkOutput("start_o", bus.fab_start_o, expStart);
      checkOutput("wr_o", bus.fab_wr_o, expWr);
      checkOutput("busy_o", bus.busy_o, expBusy);
      checkOutput("err_o", bus.err_o, expErr);
      checkOutput("fab_operand_a", bus.fab_operand_a_o, expOpA);
      checkOutput("fab_operand_b", bus.fab_operand_b_o, expOpB);
      checkOutput("fab_operator", bus.fab_operator_o, expOper);
      checkOutput("result_a", bus.efpga_result_a_o, expResA);
      checkOutput("result_b", bus.efpga_result_b_o, expResB);
      checkOutput("result_c", bus.efpga_result_c_o, expResC);
    end
    if (bus.efpga_done_o === 1'b1) begin
      doneCount++;
      lastDoneEdge = cyc;
    end
    if (bus.fab_start_o === 1'b1) begin
      startCount++;
      lastStartEdge = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int donesBefore;
    int startsBefore;
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    bus.fab_done_i     = 1'b0;
    bus.fab_result_a_i = 32'd0;
    bus.fab_result_b_i = 32'd0;
    bus.fab_result_c_i = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", bus.busy_o, 32'd0);
    checkOutput("reset_done", bus.efpga_done_o, 32'd0);
    checkOutput("reset_result_a", bus.efpga_result_a_o, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] timed mode, D=3");
    bus.fab_result_a_i = 32'd12;
    bus.fab_result_b_i = 32'h0000_0021;
    bus.fab_result_c_i = 32'hC0FF_EE00;
    applyStimulus(1'b1, 2'b00, 32'd5, 32'd7, 4'd3, 1'b0);
    @(negedge clk);
    checkOutput("timed_start", bus.fab_start_o, 32'd1);
    bus.efpga_operand_a_i = 32'd99;
    waitForDone(40, "timed_wait");
    bus.efpga_en_i = 1'b0;
    checkOutput("timed_done_cycle", 32'(lastDoneEdge - mL + 1), 32'd7);
    checkOutput("timed_start_cycle", 32'(lastStartEdge - mL + 1), 32'd1);
    checkOutput("timed_result_a", bus.efpga_result_a_o, 32'd12);
    checkOutput("timed_operand_a", bus.fab_operand_a_o, 32'd5);
    @(negedge clk);
    checkOutput("timed_done_width", bus.efpga_done_o, 32'd0);

    $display("[TB] handshake mode, early fabric done");
    bus.fab_result_a_i = 32'h1234_5678;
    applyStimulus(1'b1, 2'b01, 32'h10, 32'h20, 4'd5, 1'b0);
    @(negedge clk);
    bus.efpga_write_strobe_i = 1'b1;
    bus.efpga_operand_a_i    = 32'hDEAD_0000;
    @(negedge clk);
    bus.efpga_write_strobe_i = 1'b0;
    bus.fab_done_i = 1'b1;
    @(negedge clk);
    bus.fab_done_i = 1'b0;
    waitForDone(40, "early_wait");
    bus.efpga_en_i = 1'b0;
    checkOutput("early_done_cycle", 32'(lastDoneEdge - mL + 1), 32'd9);
    checkOutput("early_result_a", bus.efpga_result_a_o, 32'h1234_5678);
    @(negedge clk);

    $display("[TB] handshake mode, late fabric done");
    bus.fab_result_a_i = 32'h0BAD_CAFE;
    applyStimulus(1'b1, 2'b01, 32'h30, 32'h40, 4'd0, 1'b0);
    repeat (LateK) @(negedge clk);
    bus.fab_done_i = 1'b1;
    @(negedge clk);
    bus.fab_done_i = 1'b0;
    waitForDone(10, "late_wait");
    bus.efpga_en_i = 1'b0;
    checkOutput("late_done_cycle", 32'(lastDoneEdge - mL + 1), 32'(LateK + 2));
    @(negedge clk);

    $display("[TB] preload strobe");
    applyStimulus(1'b0, 2'b00, 32'hA5A5_0000, 32'h0000_5A5A, 4'd0, 1'b1);
    @(negedge clk);
    bus.efpga_write_strobe_i = 1'b0;
    checkOutput("preload_wr", bus.fab_wr_o, 32'd1);
    checkOutput("preload_operand_a", bus.fab_operand_a_o, 32'hA5A5_0000);
    checkOutput("preload_busy", bus.busy_o, 32'd0);
    @(negedge clk);
    checkOutput("preload_wr_width", bus.fab_wr_o, 32'd0);

    $display("[TB] strobe collides with en");
    bus.fab_result_a_i = 32'h1111_0001;
    applyStimulus(1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222, 4'd1, 1'b1);
    @(negedge clk);
    bus.efpga_write_strobe_i = 1'b0;
    checkOutput("collide_wr", bus.fab_wr_o, 32'd0);
    checkOutput("collide_start", bus.fab_start_o, 32'd1);
    waitForDone(20, "collide_wait");
    bus.efpga_en_i = 1'b0;
    @(negedge clk);

    $display("[TB] en held after done");
    donesBefore  = doneCount;
    startsBefore = startCount;
    bus.fab_result_a_i = 32'h4444_0004;
    applyStimulus(1'b1, 2'b10, 32'd3, 32'd4, 4'd2, 1'b0);
    waitForDone(20, "hold_wait");
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold_busy", bus.busy_o, 32'd1);
    end
    bus.efpga_en_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("hold_single_done", 32'(doneCount - donesBefore), 32'd1);
    checkOutput("hold_no_relaunch", 32'(startCount - startsBefore), 32'd1);
    checkOutput("hold_idle_busy", bus.busy_o, 32'd0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 2'b00, 32'h77, 32'h88, 4'd8, 1'b0);
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    bus.efpga_en_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", bus.busy_o, 32'd0);
    checkOutput("rst_start", bus.fab_start_o, 32'd0);
    checkOutput("rst_done", bus.efpga_done_o, 32'd0);
    checkOutput("rst_err", bus.err_o, 32'd0);
    checkOutput("rst_result_a", bus.efpga_result_a_o, 32'd0);
    checkOutput("rst_operand_a", bus.fab_operand_a_o, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

`ifdef FLEXBEX_EFPGA_TIMEOUT_EN
    $display("[TB] handshake timeout");
    applyStimulus(1'b1, 2'b01, 32'h55, 32'h66, 4'd2, 1'b0);
    waitForDone(60, "timeout_wait");
    bus.efpga_en_i = 1'b0;
    checkOutput("timeout_done_cycle", 32'(lastDoneEdge - mL + 1), 32'(TbTimeout + 3));
    checkOutput("timeout_result_a", bus.efpga_result_a_o, 32'hFFFF_FFFF);
    checkOutput("timeout_err", bus.err_o, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("timeout_err_sticky", bus.err_o, 32'd1);
    applyStimulus(1'b1, 2'b00, 32'h1, 32'h2, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("timeout_err_cleared", bus.err_o, 32'd0);
    waitForDone(20, "after_timeout_wait");
    bus.efpga_en_i = 1'b0;
`else
    $display("[TB] handshake without timeout feature");
    applyStimulus(1'b1, 2'b01, 32'h55, 32'h66, 4'd2, 1'b0);
    repeat (3) @(negedge clk);
    bus.fab_done_i = 1'b1;
    @(negedge clk);
    bus.fab_done_i = 1'b0;
    waitForDone(20, "noto_wait");
    bus.efpga_en_i = 1'b0;
    checkOutput("noto_done_cycle", 32'(lastDoneEdge - mL + 1), 32'd6);
    checkOutput("noto_err", bus.err_o, 32'd0);
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
